uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares one UART transmitter between NUM_REQ byte requesters.
- Latches the granted requester's byte and drives the transmitter's enable/data pins.
- Sequences one frame through start-handshake and done-handshake, then acknowledges the requester.
- Sits between the protocol-side byte sources and the UART transmitter; runs entirely in the clk domain.

---
 rtl/uart_arb_pkg.sv | 20 ++
 rtl/uart_rr_pick.sv | 33 +++
 rtl/uart_tx_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared state encoding and defaults for the UART transmit arbiter.
package uart_arb_pkg;

    localparam logic [2:0] ARB_IDLE    = 3'd0;
    localparam logic [2:0] ARB_GRANT   = 3'd1;
    localparam logic [2:0] ARB_LAUNCH  = 3'd2;
    localparam logic [2:0] ARB_WAIT    = 3'd3;
    localparam logic [2:0] ARB_RELEASE = 3'd4;

    localparam int LAUNCH_TIMEOUT_DEF = 1023;

    typedef enum logic [2:0] {
        ST_IDLE    = ARB_IDLE,
        ST_GRANT   = ARB_GRANT,
        ST_LAUNCH  = ARB_LAUNCH,
        ST_WAIT    = ARB_WAIT,
        ST_RELEASE = ARB_RELEASE
    } arb_state_e;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin search: first set request after ptr_i, wrapping modulo NUM_REQ.
module uart_rr_pick
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic               any_o,
    output logic [ID_W-1:0]    idx_o
);

    int pos;

    // Walk from the farthest candidate to the nearest so the nearest set bit wins.
    always_comb begin
        any_o = 1'b0;
        idx_o = '0;
        pos   = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            pos = int'(ptr_i) + k;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            if (req_i[pos[ID_W-1:0]]) begin
                any_o = 1'b1;
                idx_o = pos[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte requesters.
// Define UART_ARB_TIMEOUT_EN to abort a launch when the transmitter never raises busy.
//
// state   | meaning
// IDLE    | waiting for any req_valid; latches winner index and byte
// GRANT   | frame owned, raise tx_en
// LAUNCH  | hold tx_en until transmitter reports busy
// WAIT    | wait for a rising edge of tx_done
// RELEASE | one-cycle ack to the owner, pointer moves to it
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int ID_W           = 2,
    parameter int LAUNCH_TIMEOUT = LAUNCH_TIMEOUT_DEF
) (
    input  logic                 clk,
    input  logic                 arst_n,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ack,
    output logic                 tx_en,
    output logic [7:0]           tx_byte,
    input  logic                 tx_busy,
    input  logic                 tx_done,
    output logic [ID_W-1:0]      grant_id,
    output logic                 active,
    output logic                 abort
);

    localparam logic [ID_W-1:0] PTR_RST = ID_W'(NUM_REQ - 1);

    arb_state_e      state_q, state_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [ID_W-1:0] grant_q, grant_d;
    logic [7:0]      byte_q, byte_d;
    logic            tx_en_q, tx_en_d;
    logic            active_q, active_d;
    logic            done_q;
    logic            done_rise;
    logic            pick_any;
    logic [ID_W-1:0] pick_idx;
    logic [7:0]      pick_byte;
    logic            timeout_hit;

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req_i (req_valid),
        .ptr_i (ptr_q),
        .any_o (pick_any),
        .idx_o (pick_idx)
    );

    always_comb begin
        pick_byte = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == ID_W'(i)) begin
                pick_byte = req_data[8*i +: 8];
            end
        end
    end

    assign done_rise = tx_done & ~done_q;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(LAUNCH_TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign timeout_hit = (cnt_q == CNT_W'(LAUNCH_TIMEOUT));

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ST_GRANT) begin
            cnt_d = '0;
        end else if (state_q == ST_LAUNCH && !timeout_hit) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cnt_q <= '0;
        end else if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_timeout;

    assign timeout_hit    = 1'b0;
    assign unused_timeout = ^LAUNCH_TIMEOUT;
`endif

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        byte_d   = byte_q;
        tx_en_d  = tx_en_q;
        active_d = active_q;
        req_ack  = '0;
        abort    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    grant_d  = pick_idx;
                    byte_d   = pick_byte;
                    active_d = 1'b1;
                    state_d  = ST_GRANT;
                end
            end
            ST_GRANT: begin
                tx_en_d = 1'b1;
                state_d = ST_LAUNCH;
            end
            ST_LAUNCH: begin
                if (tx_busy) begin
                    tx_en_d = 1'b0;
                    state_d = ST_WAIT;
                end else if (timeout_hit) begin
                    // Give up on this owner but still rotate past it.
                    tx_en_d  = 1'b0;
                    abort    = 1'b1;
                    ptr_d    = grant_q;
                    active_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (done_rise) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                req_ack  = NUM_REQ'(1) << grant_q;
                ptr_d    = grant_q;
                active_d = 1'b0;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q  <= ST_IDLE;
            ptr_q    <= PTR_RST;
            grant_q  <= '0;
            byte_q   <= '0;
            tx_en_q  <= 1'b0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else if (rst) begin
            state_q  <= ST_IDLE;
            ptr_q    <= PTR_RST;
            grant_q  <= '0;
            byte_q   <= '0;
            tx_en_q  <= 1'b0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            byte_q   <= byte_d;
            tx_en_q  <= tx_en_d;
            active_q <= active_d;
            done_q   <= tx_done;
        end
    end

    assign tx_en    = tx_en_q;
    assign tx_byte  = byte_q;
    assign grant_id = grant_q;
    assign active   = active_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter; the timeout scenario runs when UART_ARB_TIMEOUT_EN is defined.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int IW = 2;
    localparam int LT = 15;

    logic           clk = 1'b0;
    logic           arst_n;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*8-1:0] req_data;
    logic [N-1:0]   req_ack;
    logic           tx_en;
    logic [7:0]     tx_byte;
    logic           tx_busy;
    logic           tx_done;
    logic [IW-1:0]  grant_id;
    logic           active;
    logic           abort;

    int n_cmp = 0;
    int n_bad = 0;
    int ptr_m;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ        (N),
        .ID_W           (IW),
        .LAUNCH_TIMEOUT (LT)
    ) dut (
        .clk       (clk),
        .arst_n    (arst_n),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ack   (req_ack),
        .tx_en     (tx_en),
        .tx_byte   (tx_byte),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done),
        .grant_id  (grant_id),
        .active    (active),
        .abort     (abort)
    );

    // Reference: nearest valid requester strictly after the last owner, modulo N.
    function automatic int exp_pick(input logic [N-1:0] v, input int p);
        for (int d = 1; d <= N; d++) begin
            if (|(v & (N'(1) << ((p + d) % N)))) return (p + d) % N;
        end
        return -1;
    endfunction

    function automatic logic [7:0] byte_of(input int i);
        logic [N*8-1:0] t;
        t = req_data >> (8 * i);
        return t[7:0];
    endfunction

    function automatic logic [N-1:0] onehot(input int i);
        return N'(1) << i;
    endfunction

    // Plays the transmitter for one frame and reports what it observed.
    // flags: 1 no tx_en, 2 byte/en unstable before busy, 4 tx_en not dropped, 8 early ack, 16 abort, 32 active low
    task automatic serve_frame(input int busy_dly, output int id, output logic [7:0] byt,
                               output int en_wait, output logic [N-1:0] ack, output int flags);
        flags = 0; en_wait = 0; ack = '0; id = -1; byt = 8'h00;
        forever begin
            @(negedge clk);
            en_wait++;
            if (abort !== 1'b0) flags |= 16;
            if (req_ack !== '0) flags |= 8;
            if (tx_en === 1'b1) break;
            if (en_wait > 40) begin
                flags |= 1;
                return;
            end
        end
        id  = int'(grant_id);
        byt = tx_byte;
        repeat (busy_dly) begin
            @(negedge clk);
            if (tx_en !== 1'b1 || tx_byte !== byt) flags |= 2;
        end
        tx_busy = 1'b1;
        @(negedge clk);
        if (tx_en !== 1'b0) flags |= 4;
        repeat (3) begin
            @(negedge clk);
            if (req_ack !== '0) flags |= 8;
            if (active !== 1'b1) flags |= 32;
            if (abort !== 1'b0) flags |= 16;
        end
        tx_busy = 1'b0;
        tx_done = 1'b1;
        @(negedge clk);
        ack     = req_ack;
        tx_done = 1'b0;
    endtask

    task automatic test_reset();
        arst_n = 1'b0; rst = 1'b0; req_valid = '0; req_data = '0;
        tx_busy = 1'b0; tx_done = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({tx_en, active, abort, req_ack, grant_id, tx_byte} !== '0) begin
            n_bad++;
            $display("FAIL reset_hold: got %0h expected 0", {tx_en, active, abort, req_ack, grant_id, tx_byte});
        end
        arst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({tx_en, active, abort, req_ack, grant_id, tx_byte} !== '0) begin
            n_bad++;
            $display("FAIL reset_idle: got %0h expected 0", {tx_en, active, abort, req_ack, grant_id, tx_byte});
        end
        ptr_m = N - 1;
    endtask

    task automatic test_all_four();
        int id, ew, fl, exp, prev;
        logic [7:0] b;
        logic [N-1:0] ack;
        req_data  = {8'h43, 8'h32, 8'h21, 8'h10};
        req_valid = 4'b1111;
        prev = -1;
        for (int f = 0; f < 5; f++) begin
            exp = exp_pick(req_valid, ptr_m);
            serve_frame(1, id, b, ew, ack, fl);
            n_cmp++; if (id !== exp) begin n_bad++; $display("FAIL all4_grant[%0d]: got %0d expected %0d", f, id, exp); end
            n_cmp++; if (b !== byte_of(exp)) begin n_bad++; $display("FAIL all4_byte[%0d]: got %0h expected %0h", f, b, byte_of(exp)); end
            n_cmp++; if (ack !== onehot(exp)) begin n_bad++; $display("FAIL all4_ack[%0d]: got %0b expected %0b", f, ack, onehot(exp)); end
            n_cmp++; if (id === prev) begin n_bad++; $display("FAIL all4_repeat[%0d]: got %0d expected not %0d", f, id, prev); end
            n_cmp++; if (ew !== (f == 0 ? 2 : 3)) begin n_bad++; $display("FAIL all4_spacing[%0d]: got %0d expected %0d", f, ew, (f == 0 ? 2 : 3)); end
            n_cmp++; if (fl !== 0) begin n_bad++; $display("FAIL all4_flags[%0d]: got %0h expected 0", f, fl); end
            prev  = id;
            ptr_m = exp;
        end
        req_valid = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single();
        int id, ew, fl;
        logic [7:0] b;
        logic [N-1:0] ack;
        req_data       = {$urandom, $urandom} ;
        req_data[15:8] = 8'hA5;
        req_valid      = 4'b0010;
        serve_frame(2, id, b, ew, ack, fl);
        n_cmp++; if (id !== 1) begin n_bad++; $display("FAIL single_grant: got %0d expected 1", id); end
        n_cmp++; if (b !== 8'hA5) begin n_bad++; $display("FAIL single_byte: got %0h expected a5", b); end
        n_cmp++; if (ew !== 2) begin n_bad++; $display("FAIL single_latency: got %0d expected 2", ew); end
        n_cmp++; if (ack !== 4'b0010) begin n_bad++; $display("FAIL single_ack: got %0b expected 0010", ack); end
        n_cmp++; if (fl !== 0) begin n_bad++; $display("FAIL single_flags: got %0h expected 0", fl); end
        req_valid = '0;
        @(negedge clk);
        n_cmp++;
        if ({req_ack, active} !== '0) begin
            n_bad++;
            $display("FAIL single_after: got %0h expected 0", {req_ack, active});
        end
        ptr_m = 1;
        @(negedge clk);
    endtask

    task automatic test_pointer();
        int id, ew, fl;
        logic [7:0] b;
        logic [N-1:0] ack;
        req_valid = 4'b0100;
        serve_frame(0, id, b, ew, ack, fl);
        n_cmp++; if (id !== 2) begin n_bad++; $display("FAIL ptr_setup: got %0d expected 2", id); end
        req_valid = 4'b1001;
        serve_frame(0, id, b, ew, ack, fl);
        n_cmp++; if (id !== 3) begin n_bad++; $display("FAIL ptr_first: got %0d expected 3", id); end
        n_cmp++; if (ack !== 4'b1000) begin n_bad++; $display("FAIL ptr_first_ack: got %0b expected 1000", ack); end
        req_valid = 4'b0001;
        serve_frame(0, id, b, ew, ack, fl);
        n_cmp++; if (id !== 0) begin n_bad++; $display("FAIL ptr_second: got %0d expected 0", id); end
        req_valid = '0;
        ptr_m = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_stale_done();
        int k, bad;
        req_valid = 4'b0001;
        k = 0;
        while (tx_en !== 1'b1 && k < 40) begin @(negedge clk); k++; end
        n_cmp++; if (tx_en !== 1'b1) begin n_bad++; $display("FAIL stale_launch: got %0b expected 1", tx_en); end
        tx_busy = 1'b1;
        tx_done = 1'b1;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            tx_busy = 1'b0;
            if (req_ack !== '0 || active !== 1'b1) bad++;
        end
        n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL stale_ignored: got %0d bad cycles expected 0", bad); end
        tx_done = 1'b0;
        @(negedge clk);
        n_cmp++; if (req_ack !== '0) begin n_bad++; $display("FAIL stale_low: got %0b expected 0", req_ack); end
        tx_done = 1'b1;
        @(negedge clk);
        n_cmp++; if (req_ack !== 4'b0001) begin n_bad++; $display("FAIL stale_release: got %0b expected 0001", req_ack); end
        tx_done   = 1'b0;
        req_valid = '0;
        ptr_m = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int k, id, ew, fl, acks;
        logic [7:0] b;
        logic [N-1:0] ack;
        req_valid = 4'b0010;
        k = 0;
        while (tx_en !== 1'b1 && k < 40) begin @(negedge clk); k++; end
        tx_busy = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1; tx_busy = 1'b0; req_valid = '0;
        @(negedge clk);
        n_cmp++;
        if ({tx_en, active, req_ack, grant_id} !== '0) begin
            n_bad++;
            $display("FAIL rst_mid: got %0h expected 0", {tx_en, active, req_ack, grant_id});
        end
        rst = 1'b0;
        tx_done = 1'b1;
        acks = 0;
        repeat (3) begin @(negedge clk); if (req_ack !== '0) acks++; end
        tx_done = 1'b0;
        n_cmp++; if (acks !== 0) begin n_bad++; $display("FAIL rst_no_ack: got %0d expected 0", acks); end
        ptr_m = N - 1;
        req_data[23:16] = 8'h5C;
        req_valid = 4'b0100;
        serve_frame(1, id, b, ew, ack, fl);
        n_cmp++; if (id !== 2 || b !== 8'h5C) begin n_bad++; $display("FAIL rst_resume: got %0d/%0h expected 2/5c", id, b); end
        n_cmp++; if (ack !== 4'b0100 || ew !== 2) begin n_bad++; $display("FAIL rst_resume_ack: got %0b/%0d expected 0100/2", ack, ew); end
        req_valid = '0;
        ptr_m = 2;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_random();
        int id, ew, fl, exp;
        logic [7:0] b, eb;
        logic [N-1:0] ack;
        for (int f = 0; f < 20; f++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
                    req_valid[i] = 1'b1;
                    req_data[8*i +: 8] = 8'($urandom);
                end
            end
            if (req_valid == '0) begin
                exp = $urandom_range(0, N - 1);
                req_valid[exp] = 1'b1;
                req_data[8*exp +: 8] = 8'($urandom);
            end
            exp = exp_pick(req_valid, ptr_m);
            eb  = byte_of(exp);
            serve_frame($urandom_range(0, 3), id, b, ew, ack, fl);
            n_cmp++; if (id !== exp) begin n_bad++; $display("FAIL rand_grant[%0d]: got %0d expected %0d", f, id, exp); end
            n_cmp++; if (b !== eb) begin n_bad++; $display("FAIL rand_byte[%0d]: got %0h expected %0h", f, b, eb); end
            n_cmp++; if (ack !== onehot(exp)) begin n_bad++; $display("FAIL rand_ack[%0d]: got %0b expected %0b", f, ack, onehot(exp)); end
            n_cmp++; if (fl !== 0) begin n_bad++; $display("FAIL rand_flags[%0d]: got %0h expected 0", f, fl); end
            req_valid[exp] = 1'b0;
            ptr_m = exp;
        end
        req_valid = '0;
        repeat (2) @(negedge clk);
    endtask

`ifdef UART_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int k, acks, exp, exp2, id, ew, fl;
        logic [7:0] b;
        logic [N-1:0] ack;
        req_valid = 4'b0011;
        exp  = exp_pick(req_valid, ptr_m);
        k = 0;
        while (active !== 1'b1 && k < 40) begin @(negedge clk); k++; end
        k = 0; acks = 0;
        while (abort !== 1'b1 && k < 40) begin
            @(negedge clk); k++;
            if (req_ack !== '0) acks++;
        end
        n_cmp++; if (k !== LT + 1) begin n_bad++; $display("FAIL to_delay: got %0d expected %0d", k, LT + 1); end
        @(negedge clk);
        n_cmp++;
        if ({tx_en, active, abort, req_ack} !== '0) begin
            n_bad++;
            $display("FAIL to_after: got %0h expected 0", {tx_en, active, abort, req_ack});
        end
        n_cmp++; if (acks !== 0) begin n_bad++; $display("FAIL to_no_ack: got %0d expected 0", acks); end
        ptr_m = exp;
        exp2  = exp_pick(req_valid, ptr_m);
        serve_frame(0, id, b, ew, ack, fl);
        n_cmp++; if (id !== exp2 || id === exp) begin n_bad++; $display("FAIL to_next: got %0d expected %0d", id, exp2); end
        n_cmp++; if (ack !== onehot(exp2)) begin n_bad++; $display("FAIL to_next_ack: got %0b expected %0b", ack, onehot(exp2)); end
        req_valid = '0;
        ptr_m = exp2;
        repeat (2) @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_all_four();
        test_single();
        test_pointer();
        test_stale_done();
        test_reset_mid();
        test_random();
`ifdef UART_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
